// File: rtl/banco_pkg.sv
// Shared types and default sizes for the multi-port register bank.
// Holds the clear-sequence FSM states.
package banco_pkg;

    typedef enum logic {
        OCIOSO   = 1'b0,
        LIMPANDO = 1'b1
    } estado_t;

    localparam int BITS_PALAVRA_PAD  = 16;
    localparam int END_REGISTROS_PAD = 3;

endpackage

// File: rtl/banco_registro_mp_porta_leitura.sv
// One read port: selects a register, forwarding a same-edge write
// or a same-edge clear so the registered output sees the new value.
module porta_leitura
    import banco_pkg::*;
#(
    parameter int BITS_PALAVRA  = BITS_PALAVRA_PAD,
    parameter int END_REGISTROS = END_REGISTROS_PAD,
    parameter int R0_ZERO       = 0
) (
    input  logic [END_REGISTROS-1:0]                         sel,
    input  logic [2**END_REGISTROS-1:0][BITS_PALAVRA-1:0]    registros,
    input  logic                                             escrita,
    input  logic [END_REGISTROS-1:0]                         sel_e,
    input  logic [BITS_PALAVRA-1:0]                          e,
    input  logic                                             limpando,
    input  logic [END_REGISTROS-1:0]                         contador,
    output logic [BITS_PALAVRA-1:0]                          dado
);

    // Priority: hardwired zero, clear bypass, write bypass, storage.
    always_comb begin
        dado = registros[sel];
        if (R0_ZERO != 0 && sel == '0) begin
            dado = '0;
        end else if (limpando && sel == contador) begin
            dado = '0;
        end else if (escrita && sel == sel_e) begin
            dado = e;
        end
    end

endmodule

// File: rtl/banco_registro_mp.sv
// Register bank with one write port, two registered read ports and
// a sequential clear that zeroes one register per cycle.
module banco_registro_mp
    import banco_pkg::*;
#(
    parameter int BITS_PALAVRA  = BITS_PALAVRA_PAD,
    parameter int END_REGISTROS = END_REGISTROS_PAD,
    parameter int R0_ZERO       = 0
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     hab_escrita,
    input  logic [END_REGISTROS-1:0] sel_e,
    input  logic [BITS_PALAVRA-1:0]  e,
    input  logic [END_REGISTROS-1:0] sel_a,
    input  logic [END_REGISTROS-1:0] sel_b,
    output logic [BITS_PALAVRA-1:0]  a,
    output logic [BITS_PALAVRA-1:0]  b,
    input  logic                     limpar,
    output logic                     ocupado
);

    localparam int NUM_REGISTROS = 2**END_REGISTROS;
    localparam logic [END_REGISTROS-1:0] ULTIMO =
        END_REGISTROS'(NUM_REGISTROS - 1);

    logic [NUM_REGISTROS-1:0][BITS_PALAVRA-1:0] registros;
    estado_t                  estado;
    estado_t                  proximo;
    logic [END_REGISTROS-1:0] contador;
    logic                     limpando;
    logic                     escrita;
    logic [BITS_PALAVRA-1:0]  dado_a;
    logic [BITS_PALAVRA-1:0]  dado_b;

    assign limpando = (estado == LIMPANDO);

    // A write needs an idle bank and no competing clear request;
    // writes to a hardwired-zero r0 are discarded here.
    assign escrita = hab_escrita && (estado == OCIOSO) && !limpar
                     && !(R0_ZERO != 0 && sel_e == '0);

    // Next-state: start on limpar, finish after the last index.
    always_comb begin
        proximo = estado;
        unique case (estado)
            OCIOSO:   if (limpar) proximo = LIMPANDO;
            LIMPANDO: if (contador == ULTIMO) proximo = OCIOSO;
            default:  proximo = OCIOSO;
        endcase
    end

    // FSM state, busy flag and clear index.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado   <= OCIOSO;
            ocupado  <= 1'b0;
            contador <= '0;
        end else begin
            estado  <= proximo;
            ocupado <= (proximo == LIMPANDO);
            if (limpando) begin
                contador <= (contador == ULTIMO) ? '0 : contador + 1'b1;
            end
        end
    end

    // Storage: clear has priority; writes only when idle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            registros <= '0;
        end else if (limpando) begin
            registros[contador] <= '0;
        end else if (escrita) begin
            registros[sel_e] <= e;
        end
    end

    porta_leitura #(
        .BITS_PALAVRA  (BITS_PALAVRA),
        .END_REGISTROS (END_REGISTROS),
        .R0_ZERO       (R0_ZERO)
    ) u_porta_a (
        .sel       (sel_a),
        .registros (registros),
        .escrita   (escrita),
        .sel_e     (sel_e),
        .e         (e),
        .limpando  (limpando),
        .contador  (contador),
        .dado      (dado_a)
    );

    porta_leitura #(
        .BITS_PALAVRA  (BITS_PALAVRA),
        .END_REGISTROS (END_REGISTROS),
        .R0_ZERO       (R0_ZERO)
    ) u_porta_b (
        .sel       (sel_b),
        .registros (registros),
        .escrita   (escrita),
        .sel_e     (sel_e),
        .e         (e),
        .limpando  (limpando),
        .contador  (contador),
        .dado      (dado_b)
    );

    // Registered read outputs, refreshed every cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a <= '0;
            b <= '0;
        end else begin
            a <= dado_a;
            b <= dado_b;
        end
    end

endmodule

// File: tb/tb_banco_registro_mp.sv
// Bench for banco_registro_mp: a 16x8 bank and a 32x16 bank with
// hardwired r0 share stimulus and are checked against array models.
module tb_banco_registro_mp;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        hab_escrita;
    logic [3:0]  sel_e;
    logic [31:0] e;
    logic [3:0]  sel_a;
    logic [3:0]  sel_b;
    logic        limpar;
    logic [15:0] a0, b0;
    logic [31:0] a1, b1;
    logic        oc0, oc1;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [2][16];
    int          busy [2];
    logic [31:0] exp_a [2];
    logic [31:0] exp_b [2];
    logic        exp_oc [2];
    int          num_r [2] = '{8, 16};
    logic [31:0] mask [2] = '{32'h0000_FFFF, 32'hFFFF_FFFF};
    bit          r0z [2] = '{1'b0, 1'b1};

    always #5 clock = ~clock;

    banco_registro_mp #(
        .BITS_PALAVRA(16), .END_REGISTROS(3), .R0_ZERO(0)
    ) dut0 (
        .clock(clock), .reset_n(reset_n), .hab_escrita(hab_escrita),
        .sel_e(sel_e[2:0]), .e(e[15:0]),
        .sel_a(sel_a[2:0]), .sel_b(sel_b[2:0]),
        .a(a0), .b(b0), .limpar(limpar), .ocupado(oc0)
    );

    banco_registro_mp #(
        .BITS_PALAVRA(32), .END_REGISTROS(4), .R0_ZERO(1)
    ) dut1 (
        .clock(clock), .reset_n(reset_n), .hab_escrita(hab_escrita),
        .sel_e(sel_e), .e(e), .sel_a(sel_a), .sel_b(sel_b),
        .a(a1), .b(b1), .limpar(limpar), .ocupado(oc1)
    );

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) mem[d][i] = '0;
            busy[d] = 0;
            exp_a[d] = '0;
            exp_b[d] = '0;
            exp_oc[d] = 1'b0;
        end
    endtask

    // Behaviour of one rising edge: storage is updated first, then the
    // ports read the updated contents (which gives both bypasses).
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            int ie, ia, ib;
            ie = int'(sel_e) % num_r[d];
            ia = int'(sel_a) % num_r[d];
            ib = int'(sel_b) % num_r[d];
            if (busy[d] > 0) begin
                mem[d][num_r[d] - busy[d]] = '0;
                busy[d]--;
            end else if (limpar) begin
                busy[d] = num_r[d];
            end else if (hab_escrita && !(r0z[d] && ie == 0)) begin
                mem[d][ie] = e & mask[d];
            end
            exp_a[d] = (r0z[d] && ia == 0) ? '0 : mem[d][ia];
            exp_b[d] = (r0z[d] && ib == 0) ? '0 : mem[d][ib];
            exp_oc[d] = (busy[d] > 0);
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        hab_escrita = 1'b0;
        limpar = 1'b0;
        sel_e = '0; e = '0; sel_a = '0; sel_b = '0;
        model_reset();
        #2;
        checks++;
        if ({a0, b0, oc0, a1, b1, oc1} !== '0) begin
            errors++;
            $display("FAIL reset: got a0=%h b0=%h oc0=%b a1=%h b1=%h oc1=%b, want zeros",
                     a0, b0, oc0, a1, b1, oc1);
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_write_read();
        hab_escrita = 1'b1; sel_e = 4'd2; e = 32'h0000_6BD5;
        sel_a = 4'd0; sel_b = 4'd1;
        step();
        hab_escrita = 1'b0; sel_a = 4'd2; sel_b = 4'd3;
        step();
        checks++;
        if (a0 !== 16'h6BD5 || a1 !== 32'h0000_6BD5) begin
            errors++;
            $display("FAIL write_read: a0=%h a1=%h want 6bd5", a0, a1);
        end
        checks++;
        if (b0 !== exp_b[0][15:0] || b1 !== exp_b[1]) begin
            errors++;
            $display("FAIL write_read_b: b0=%h b1=%h want %h %h",
                     b0, b1, exp_b[0][15:0], exp_b[1]);
        end
    endtask

    task automatic test_bypass();
        hab_escrita = 1'b1; sel_e = 4'd5; e = 32'hA5A5_1DD6;
        sel_a = 4'd5; sel_b = 4'd5;
        step();
        checks++;
        if (a0 !== 16'h1DD6 || b0 !== 16'h1DD6) begin
            errors++;
            $display("FAIL bypass16: a0=%h b0=%h want 1dd6", a0, b0);
        end
        checks++;
        if (a1 !== 32'hA5A5_1DD6 || b1 !== 32'hA5A5_1DD6) begin
            errors++;
            $display("FAIL bypass32: a1=%h b1=%h want a5a51dd6", a1, b1);
        end
        hab_escrita = 1'b0;
    endtask

    task automatic test_r0();
        hab_escrita = 1'b1; sel_e = 4'd0; e = 32'hFFFF_FFFF;
        sel_a = 4'd0; sel_b = 4'd0;
        step();
        checks++;
        if (a0 !== 16'hFFFF || a1 !== 32'h0 || b1 !== 32'h0) begin
            errors++;
            $display("FAIL r0_same: a0=%h a1=%h b1=%h want ffff 0 0",
                     a0, a1, b1);
        end
        hab_escrita = 1'b0;
        step();
        checks++;
        if (b0 !== 16'hFFFF || a1 !== 32'h0) begin
            errors++;
            $display("FAIL r0_next: b0=%h a1=%h want ffff 0", b0, a1);
        end
    endtask

    task automatic test_clear();
        int hi0, hi1;
        hi0 = 0; hi1 = 0;
        for (int i = 0; i < 16; i++) begin
            hab_escrita = 1'b1; sel_e = 4'(i);
            e = $urandom() | 32'h0001_0001;
            if (i == 15) e = 32'hDEAD_BEEF;
            step();
        end
        limpar = 1'b1;
        step();
        limpar = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (oc0) hi0++;
            if (oc1) hi1++;
            hab_escrita = (k < 8);
            sel_e = 4'($urandom_range(0, 15));
            e = $urandom();
            limpar = (k == 3);
            sel_a = 4'($urandom_range(0, 15));
            sel_b = 4'($urandom_range(0, 15));
            step();
            checks++;
            if ({a0, b0, oc0} !== {exp_a[0][15:0], exp_b[0][15:0], exp_oc[0]}
                || {a1, b1, oc1} !== {exp_a[1], exp_b[1], exp_oc[1]}) begin
                errors++;
                $display("FAIL clear_seq k=%0d: a0=%h b0=%h oc0=%b a1=%h b1=%h oc1=%b want %h %h %b %h %h %b",
                         k, a0, b0, oc0, a1, b1, oc1,
                         exp_a[0][15:0], exp_b[0][15:0], exp_oc[0],
                         exp_a[1], exp_b[1], exp_oc[1]);
            end
        end
        limpar = 1'b0;
        checks++;
        if (hi0 !== 8 || hi1 !== 16) begin
            errors++;
            $display("FAIL busy_len: got %0d/%0d cycles want 8/16", hi0, hi1);
        end
        hab_escrita = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sel_a = 4'(i); sel_b = 4'(15 - i);
            step();
            checks++;
            if (a0 !== 16'h0 || b0 !== 16'h0 || a1 !== 32'h0 || b1 !== 32'h0) begin
                errors++;
                $display("FAIL cleared r%0d: a0=%h b0=%h a1=%h b1=%h want 0",
                         i, a0, b0, a1, b1);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        for (int i = 0; i < 8; i++) begin
            hab_escrita = 1'b1; sel_e = 4'(i); e = 32'h0100 + 32'(i);
            step();
        end
        hab_escrita = 1'b0;
        limpar = 1'b1;
        step();
        limpar = 1'b0;
        step();
        step();
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({a0, b0, oc0, a1, b1, oc1} !== '0) begin
            errors++;
            $display("FAIL mid_reset: a0=%h b0=%h oc0=%b a1=%h b1=%h oc1=%b want zeros",
                     a0, b0, oc0, a1, b1, oc1);
        end
        #2;
        reset_n = 1'b1;
        hab_escrita = 1'b1; sel_e = 4'd7; e = 32'h0000_00AB;
        step();
        hab_escrita = 1'b0; sel_a = 4'd7; sel_b = 4'd6;
        step();
        checks++;
        if (a0 !== 16'h00AB || a1 !== 32'h0000_00AB || b0 !== 16'h0
            || oc0 !== 1'b0 || oc1 !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: a0=%h a1=%h b0=%h oc=%b%b want ab ab 0 00",
                     a0, a1, b0, oc0, oc1);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            hab_escrita = ($urandom_range(0, 3) != 0);
            limpar = ($urandom_range(0, 40) == 0);
            sel_e = 4'($urandom_range(0, 15));
            e = $urandom();
            sel_a = 4'($urandom_range(0, 15));
            sel_b = ($urandom_range(0, 3) == 0) ? sel_e
                                                 : 4'($urandom_range(0, 15));
            step();
            checks++;
            if ({a0, b0, oc0} !== {exp_a[0][15:0], exp_b[0][15:0], exp_oc[0]}) begin
                errors++;
                $display("FAIL random16 k=%0d: a=%h b=%h oc=%b want %h %h %b",
                         k, a0, b0, oc0, exp_a[0][15:0], exp_b[0][15:0], exp_oc[0]);
            end
            checks++;
            if ({a1, b1, oc1} !== {exp_a[1], exp_b[1], exp_oc[1]}) begin
                errors++;
                $display("FAIL random32 k=%0d: a=%h b=%h oc=%b want %h %h %b",
                         k, a1, b1, oc1, exp_a[1], exp_b[1], exp_oc[1]);
            end
        end
        limpar = 1'b0;
        hab_escrita = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_r0();
        test_clear();
        test_reset_mid_clear();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/banco_registro_mp.md
BANCO_REGISTRO_MP -- requirements
Module: banco_registro_mp

Interface
REQ-001 Parameter BITS_PALAVRA, default 16, data word width in bits.
REQ-002 Parameter END_REGISTROS, default 3, address width; register count NUM_REGISTROS = 2**END_REGISTROS (derived, not overridable).
REQ-003 Parameter R0_ZERO, default 0; when 1, register 0 always reads zero and ignores writes.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 hab_escrita  input  1  write enable for port E.
REQ-007 sel_e  input  END_REGISTROS  write address.
REQ-008 e  input  BITS_PALAVRA  write data.
REQ-009 sel_a, sel_b  input  END_REGISTROS each  read addresses, ports A and B.
REQ-010 a, b  output  BITS_PALAVRA each  registered read data.
REQ-011 limpar  input  1  single-cycle request to clear all registers.
REQ-012 ocupado  output  1  high while a clear sequence is in progress.

Function
REQ-013 Reads SHALL be registered: a/b reflect sel_a/sel_b sampled at edge N, valid after edge N (latency 1), updated every cycle regardless of hab_escrita.
REQ-014 Write SHALL occur at rising edge when hab_escrita=1 and FSM is OCIOSO: registro[sel_e] <= e.
REQ-015 Write-through bypass: same-edge write and read of one address SHALL return the new data e on that port.
REQ-016 Both read ports MAY address the same register; each SHALL return identical data.
REQ-017 With R0_ZERO=1, writes to address 0 SHALL be discarded and reads of address 0 (bypass included) SHALL return 0.
REQ-018 FSM states OCIOSO, LIMPANDO; OCIOSO->LIMPANDO on limpar=1; LIMPANDO->OCIOSO after clearing index NUM_REGISTROS-1.
REQ-019 In LIMPANDO, an END_REGISTROS-bit counter starting at 0 SHALL zero registro[counter] each cycle and increment; sequence lasts exactly NUM_REGISTROS cycles.
REQ-020 ocupado SHALL be registered, 1 exactly during the NUM_REGISTROS cycles in LIMPANDO, 0 from the edge returning to OCIOSO.
REQ-021 In LIMPANDO, hab_escrita SHALL be ignored (write dropped, no bypass) and limpar SHALL be ignored.
REQ-022 Reads during LIMPANDO SHALL return current contents; a read of the register being cleared that edge SHALL return 0 (clear bypass).
REQ-023 limpar and hab_escrita asserted together in OCIOSO: the write is dropped, clear starts.
REQ-024 Counter SHALL not wrap: terminal index NUM_REGISTROS-1 ends the sequence, counter returns to 0.

Reset
REQ-025 reset_n=0 SHALL asynchronously set all registers, a, b, counter to 0, ocupado to 0, FSM to OCIOSO.
REQ-026 Reset asserted mid-clear SHALL abort the sequence; no partial state survives.
REQ-027 First write SHALL be accepted on the first rising edge after reset_n deasserts.

Structure
REQ-028 Shared package banco_pkg SHALL hold the FSM state enum (OCIOSO, LIMPANDO) and default width/address constants.
REQ-029 Read-port mux with bypass SHALL be one sub-module, porta_leitura, instantiated twice (A, B); storage and FSM stay in the top.
REQ-030 No initial blocks; reset is the only initialisation.

Verification
REQ-031 Reset, write 16'h6BD5 to r2, read r2 on A next cycle -> a=16'h6BD5 one edge after read address.
REQ-032 Same edge: write 16'h1DD6 to r5, sel_a=sel_b=5 -> a=b=16'h1DD6 after that edge (bypass).
REQ-033 Fill r0..r7 with nonzero, pulse limpar -> ocupado high 8 cycles; writes during it dropped; all reads 0 afterward.
REQ-034 R0_ZERO=1: write 16'hFFFF to r0, read r0 same and next cycle -> 0; R0_ZERO=0 -> 16'hFFFF.
REQ-035 Assert reset_n=0 at clear cycle 3 -> ocupado=0, a=b=0 immediately; post-release write/read r7=16'h00AB works.
REQ-036 BITS_PALAVRA=32, END_REGISTROS=4: write 32'hDEADBEEF to r15, clear takes 16 cycles, r15 reads 0 after.
